// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-ported instruction memory between the fetch unit (read) and the loader (write).
// Round-robin on contention, registered strobes and acks, saturating completion counters.
module imem_port_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             f_req,
   input  logic [31:0]      f_addr,
   output logic             f_ack,
   output logic             f_err,
   output logic [31:0]      f_data,
   input  logic             l_req,
   input  logic [31:0]      l_addr,
   input  logic [31:0]      l_wdata,
   output logic             l_ack,
   output logic             l_err,
   output logic             im_cs,
   output logic             im_wr,
   output logic             im_rd,
   output logic [31:0]      im_addr,
   output logic [31:0]      im_din,
   input  logic [31:0]      im_dout,
   output logic             busy,
   output logic [CNT_W-1:0] f_cnt,
   output logic [CNT_W-1:0] l_cnt
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state;
   logic        owner_l;   // 1 = loader owns the current transaction
   logic        last_l;    // 1 = loader was granted last
   logic        grant_l;
   logic        misaligned;
   logic [31:0] sel_addr;

   always_comb begin
      grant_l    = l_req && (!f_req || !last_l);
      sel_addr   = grant_l ? l_addr : f_addr;
      misaligned = (sel_addr[1:0] != 2'b00);
   end

   // NOTE: every register here uses non-blocking assignment so all outputs update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         owner_l <= 1'b0;
         last_l  <= 1'b1;
         f_ack   <= 1'b0;
         f_err   <= 1'b0;
         f_data  <= '0;
         l_ack   <= 1'b0;
         l_err   <= 1'b0;
         im_cs   <= 1'b0;
         im_wr   <= 1'b0;
         im_rd   <= 1'b0;
         im_addr <= '0;
         im_din  <= '0;
         busy    <= 1'b0;
         f_cnt   <= '0;
         l_cnt   <= '0;
      end else begin
         // Strobes, bus and acks are single-cycle; the active state re-asserts them.
         f_ack   <= 1'b0;
         f_err   <= 1'b0;
         l_ack   <= 1'b0;
         l_err   <= 1'b0;
         im_cs   <= 1'b0;
         im_wr   <= 1'b0;
         im_rd   <= 1'b0;
         im_addr <= '0;
         im_din  <= '0;

         case (state)
            IDLE: begin
               if (f_req || l_req) begin
                  owner_l <= grant_l;
                  last_l  <= grant_l;
                  busy    <= 1'b1;
                  if (misaligned) begin
                     state <= RESP;
                     f_ack <= !grant_l;
                     f_err <= !grant_l;
                     l_ack <= grant_l;
                     l_err <= grant_l;
                  end else begin
                     state   <= ACCESS;
                     im_cs   <= 1'b1;
                     im_rd   <= !grant_l;
                     im_wr   <= grant_l;
                     im_addr <= sel_addr;
                     im_din  <= grant_l ? l_wdata : 32'h0;
                  end
               end
            end

            ACCESS: begin
               state <= RESP;
               if (owner_l) begin
                  l_ack <= 1'b1;
                  if (l_cnt != '1) l_cnt <= l_cnt + 1'b1;
               end else begin
                  f_ack  <= 1'b1;
                  f_data <= im_dout;
                  if (f_cnt != '1) f_cnt <= f_cnt + 1'b1;
               end
            end

            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized self-checking bench for imem_port_arbiter against a transaction-level reference model
// (grant order, latency, error flags, memory contents and saturating counts).
module tb_imem_port_arbiter;

   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             f_req, l_req;
   logic [31:0]      f_addr, l_addr, l_wdata;
   logic             f_ack, f_err, l_ack, l_err;
   logic [31:0]      f_data;
   logic             im_cs, im_wr, im_rd;
   logic [31:0]      im_addr, im_din, im_dout;
   logic             busy;
   logic [CNT_W-1:0] f_cnt, l_cnt;

   int tests = 0;
   int fails = 0;
   int cs_n = 0, rd_n = 0, wr_n = 0;

   always #5 clk = ~clk;

   imem_port_arbiter #(.CNT_W(CNT_W)) u_dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_data(f_data),
      .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack), .l_err(l_err),
      .im_cs(im_cs), .im_wr(im_wr), .im_rd(im_rd), .im_addr(im_addr), .im_din(im_din),
      .im_dout(im_dout), .busy(busy), .f_cnt(f_cnt), .l_cnt(l_cnt)
   );

   // Byte-addressed big-endian 4 KB memory; only addr[11:0] is decoded.
   logic [7:0]  mem [4096];
   logic        pl_en = 1'b0;
   logic [11:0] pl_a  = '0;
   logic [31:0] pl_w  = '0;

   always_comb begin
      im_dout = {mem[im_addr[11:0]], mem[im_addr[11:0] + 12'd1],
                 mem[im_addr[11:0] + 12'd2], mem[im_addr[11:0] + 12'd3]};
   end

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_a] <= pl_w[31:24]; mem[pl_a + 12'd1] <= pl_w[23:16];
         mem[pl_a + 12'd2] <= pl_w[15:8]; mem[pl_a + 12'd3] <= pl_w[7:0];
      end else if (im_cs && im_wr) begin
         mem[im_addr[11:0]] <= im_din[31:24]; mem[im_addr[11:0] + 12'd1] <= im_din[23:16];
         mem[im_addr[11:0] + 12'd2] <= im_din[15:8]; mem[im_addr[11:0] + 12'd3] <= im_din[7:0];
      end
   end

   // Reference model: word-level memory image, last winner, completed-access totals.
   logic [31:0] shadow [1024];
   bit          m_last_l;
   int          m_fn, m_ln;
   logic [31:0] m_fdata;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic int sat(input int n);
      return (n > CNT_MAX) ? CNT_MAX : n;
   endfunction

   task automatic model_reset();
      m_last_l = 1'b1;
      m_fn = 0;
      m_ln = 0;
      m_fdata = 32'h0;
   endtask

   task automatic model_serve(input bit is_l, input logic [31:0] a, input logic [31:0] d, output bit err);
      err = (a[1:0] != 2'b00);
      m_last_l = is_l;
      if (!err) begin
         if (is_l) begin
            shadow[a[11:2]] = d;
            m_ln++;
         end else begin
            m_fdata = shadow[a[11:2]];
            m_fn++;
         end
      end
   endtask

   task automatic preload(input logic [11:0] a, input logic [31:0] w);
      @(negedge clk);
      pl_en = 1'b1; pl_a = a; pl_w = w;
      @(negedge clk);
      pl_en = 1'b0;
      shadow[a[11:2]] = w;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; f_req = 1'b0; l_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // One transaction round: raise the selected requests together, follow each to its ack.
   task automatic txn(input bit df, input bit dl, input logic [31:0] fa, input logic [31:0] la,
                      input logic [31:0] ld);
      bit win_l, ef, el;
      int lat_f, lat_l, exp_fc, exp_lc, fc, lc, cyc, cs0, rd0, wr0;
      win_l = (df && dl) ? !m_last_l : dl;
      lat_f = (fa[1:0] != 2'b00) ? 1 : 2;
      lat_l = (la[1:0] != 2'b00) ? 1 : 2;
      ef = 1'b0; el = 1'b0; exp_fc = 0; exp_lc = 0;
      if (win_l) begin
         model_serve(1'b1, la, ld, el);
         exp_lc = lat_l;
         if (df) begin model_serve(1'b0, fa, 32'h0, ef); exp_fc = lat_l + 1 + lat_f; end
      end else begin
         model_serve(1'b0, fa, 32'h0, ef);
         exp_fc = lat_f;
         if (dl) begin model_serve(1'b1, la, ld, el); exp_lc = lat_f + 1 + lat_l; end
      end
      cs0 = cs_n; rd0 = rd_n; wr0 = wr_n;

      @(negedge clk);
      f_req = df; f_addr = fa; l_req = dl; l_addr = la; l_wdata = ld;
      fc = 0; lc = 0; cyc = 0;
      while (((df && fc == 0) || (dl && lc == 0)) && cyc < 16) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (f_ack) begin
            if (!df || fc != 0) check("f_ack_spurious", 1, 0);
            else begin
               fc = cyc; f_req = 1'b0;
               check("f_err", f_err, ef);
               check("f_data", f_data, m_fdata);
               check("busy_resp", busy, 1);
            end
         end
         if (l_ack) begin
            if (!dl || lc != 0) check("l_ack_spurious", 1, 0);
            else begin
               lc = cyc; l_req = 1'b0;
               check("l_err", l_err, el);
               check("busy_resp", busy, 1);
            end
         end
      end
      f_req = 1'b0; l_req = 1'b0;
      if (df) check("f_ack_cycle", fc, exp_fc);
      if (dl) check("l_ack_cycle", lc, exp_lc);
      @(posedge clk);
      @(negedge clk);
      check("busy_idle", busy, 0);
      check("rd_cycles", rd_n - rd0, (df && !ef) ? 1 : 0);
      check("wr_cycles", wr_n - wr0, (dl && !el) ? 1 : 0);
      check("cs_cycles", cs_n - cs0, ((df && !ef) ? 1 : 0) + ((dl && !el) ? 1 : 0));
      check("f_cnt", f_cnt, sat(m_fn));
      check("l_cnt", l_cnt, sat(m_ln));
   endtask

   // Bus protocol watcher.
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b0) begin
            if (im_cs) cs_n++;
            if (im_rd) rd_n++;
            if (im_wr) wr_n++;
            if (im_wr && im_rd) check("wr_rd_overlap", 1, 0);
            if (im_wr && !im_cs) check("wr_without_cs", 1, 0);
            if (!im_cs && (|{im_rd, im_addr, im_din})) check("bus_idle_zero", {im_rd, im_addr, im_din}, 0);
         end
      end
   end

   initial begin
      logic [31:0] tmp, fa, la, ld;
      int r;
      bit seen;
      reset = 1'b1; f_req = 1'b0; l_req = 1'b0;
      f_addr = '0; l_addr = '0; l_wdata = '0;
      for (int i = 0; i < 16; i++) preload(12'(i * 4), $urandom);
      preload(12'h010, 32'hDEADBEEF);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      check("reset_outputs", {f_ack, f_err, f_data, l_ack, l_err, im_cs, im_wr, im_rd,
                              im_addr, im_din, busy, f_cnt, l_cnt}, 0);

      // Single fetch.
      txn(1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
      check("fetch_deadbeef", f_data, 32'hDEADBEEF);

      // Load through the wrapped address, then fetch it back.
      txn(1'b0, 1'b1, 32'h0, 32'h1004, 32'h12345678);
      txn(1'b1, 1'b0, 32'h004, 32'h0, 32'h0);
      check("fetch_loaded", f_data, 32'h12345678);
      check("be_bytes", {mem[4], mem[5], mem[6], mem[7]}, 32'h12345678);

      // Contention from reset: F, L, F, L.
      do_reset();
      for (int i = 0; i < 4; i++) txn(1'b1, 1'b1, 32'(4 * i), 32'(32 + 4 * i), $urandom);

      // Misaligned load.
      do_reset();
      txn(1'b0, 1'b1, 32'h0, 32'h22, 32'hCAFEF00D);
      check("misaligned_l_cnt", l_cnt, 0);

      // Reset in the middle of a load access.
      @(negedge clk);
      l_req = 1'b1; l_addr = 32'h8; l_wdata = 32'hA5A55A5A;
      @(posedge clk);
      @(negedge clk);
      check("rst_pre_cs", im_cs, 1);
      #1 reset = 1'b1;
      #1;
      check("rst_cs_async", im_cs, 0);
      check("rst_all_zero", {f_ack, f_err, f_data, l_ack, l_err, im_cs, im_wr, im_rd,
                             im_addr, im_din, busy, f_cnt, l_cnt}, 0);
      l_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check("rst_word_kept", {mem[8], mem[9], mem[10], mem[11]}, shadow[2]);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (l_ack) seen = 1'b1;
      end
      check("rst_no_ack", seen, 0);

      // Counter saturation.
      for (int i = 0; i < 5; i++) txn(1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
      check("f_cnt_saturated", f_cnt, 3);

      // Randomized mix.
      for (int n = 0; n < 60; n++) begin
         if (n % 12 == 0) do_reset();
         r = $urandom_range(1, 3);
         tmp = $urandom;
         fa = (tmp & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2)
              | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
         tmp = $urandom;
         la = (tmp & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2)
              | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
         ld = $urandom;
         txn(r[0], r[1], fa, la, ld);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
